// File: rtl/write_scheduler.sv
// Two-master AW arbiter and write-path router: one outstanding write at a time,
// round-robin grant, address decode to a one-hot slave select, WLAST/length checking.
module write_scheduler (
    input  logic        clk,
    input  logic        rst,
    input  logic        awvalid_m0_i,
    input  logic        awvalid_m1_i,
    input  logic [31:0] awaddr_m0_i,
    input  logic [31:0] awaddr_m1_i,
    input  logic [3:0]  awlen_m0_i,
    input  logic [3:0]  awlen_m1_i,
    input  logic        awready_i,
    input  logic        wvalid_i,
    input  logic        wready_i,
    input  logic        wlast_i,
    input  logic        bvalid_i,
    input  logic        bready_i,
    output logic [1:0]  aw_grant_o,
    output logic        w_owner_o,
    output logic [5:0]  slave_sel_o,
    output logic        busy_o,
    output logic        len_err_o
);

    // state | meaning
    // IDLE  | no transaction; arbitrate incoming AW requests
    // ADDR  | grant driven to winner, waiting for awready_i
    // DATA  | counting W beats until the first beat with wlast_i
    // RESP  | waiting for the B handshake; priority updates on exit
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        prio_q, prio_d;
    logic        owner_q, owner_d;
    logic [5:0]  sel_q, sel_d;
    logic [3:0]  len_q, len_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        len_err_q, len_err_d;

    logic        any_req;
    logic        winner;
    logic [31:0] win_addr;
    logic [3:0]  win_len;
    logic [5:0]  dec_sel;
    logic        w_hs;
    logic        b_hs;

    assign any_req  = awvalid_m0_i | awvalid_m1_i;
    assign winner   = (awvalid_m0_i & awvalid_m1_i) ? prio_q : awvalid_m1_i;
    assign win_addr = winner ? awaddr_m1_i : awaddr_m0_i;
    assign win_len  = winner ? awlen_m1_i : awlen_m0_i;
    assign w_hs     = wvalid_i & wready_i;
    assign b_hs     = bvalid_i & bready_i;

    // Full-width range compares; bit3 of the select is reserved and never set.
    always_comb begin
        dec_sel = 6'b100000;
        if (win_addr <= 32'h0000_3FFF) begin
            dec_sel = 6'b000001;
        end else if (win_addr >= 32'h0001_0000 && win_addr <= 32'h0001_FFFF) begin
            dec_sel = 6'b000010;
        end else if (win_addr >= 32'h0002_0000 && win_addr <= 32'h0002_FFFF) begin
            dec_sel = 6'b000100;
        end else if ((win_addr >= 32'h1001_0000 && win_addr <= 32'h1001_03FF) ||
                     (win_addr >= 32'h2000_0000 && win_addr <= 32'h201F_FFFF)) begin
            dec_sel = 6'b010000;
        end
    end

    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        owner_d   = owner_q;
        sel_d     = sel_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        len_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d = winner;
                    sel_d   = dec_sel;
                    len_d   = win_len;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (awready_i) begin
                    cnt_d   = 4'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (w_hs) begin
                    cnt_d     = cnt_q + 4'd1;
                    len_err_d = wlast_i ? (cnt_q != len_q) : (cnt_q == len_q);
                    if (wlast_i) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (b_hs) begin
                    prio_d  = ~owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            prio_q    <= 1'b0;
            owner_q   <= 1'b0;
            sel_q     <= 6'b0;
            len_q     <= 4'd0;
            cnt_q     <= 4'd0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            owner_q   <= owner_d;
            sel_q     <= sel_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            len_err_q <= len_err_d;
        end
    end

    assign aw_grant_o  = (state_q == ADDR) ? {owner_q, ~owner_q} : 2'b00;
    assign w_owner_o   = owner_q;
    assign slave_sel_o = (state_q == IDLE) ? 6'b0 : sel_q;
    assign busy_o      = (state_q != IDLE);
    assign len_err_o   = len_err_q;

endmodule

// File: tb/tb_write_scheduler.sv
// Bench for write_scheduler: directed vector table, contention, reset and stray
// handshake sequences, then randomized transactions against a transaction-level model.
module tb_write_scheduler;

    logic        clk;
    logic        rst;
    logic        awvalid_m0_i, awvalid_m1_i;
    logic [31:0] awaddr_m0_i, awaddr_m1_i;
    logic [3:0]  awlen_m0_i, awlen_m1_i;
    logic        awready_i, wvalid_i, wready_i, wlast_i, bvalid_i, bready_i;
    logic [1:0]  aw_grant_o;
    logic        w_owner_o;
    logic [5:0]  slave_sel_o;
    logic        busy_o;
    logic        len_err_o;

    int checks   = 0;
    int failures = 0;

    // transaction-level model state
    logic prio_m      = 1'b0;
    logic last_owner  = 1'b0;

    write_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .awvalid_m0_i (awvalid_m0_i),
        .awvalid_m1_i (awvalid_m1_i),
        .awaddr_m0_i  (awaddr_m0_i),
        .awaddr_m1_i  (awaddr_m1_i),
        .awlen_m0_i   (awlen_m0_i),
        .awlen_m1_i   (awlen_m1_i),
        .awready_i    (awready_i),
        .wvalid_i     (wvalid_i),
        .wready_i     (wready_i),
        .wlast_i      (wlast_i),
        .bvalid_i     (bvalid_i),
        .bready_i     (bready_i),
        .aw_grant_o   (aw_grant_o),
        .w_owner_o    (w_owner_o),
        .slave_sel_o  (slave_sel_o),
        .busy_o       (busy_o),
        .len_err_o    (len_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  len;
        int          nbeats;
        logic [5:0]  sel;
        int          errs;
    } vec_t;

    vec_t vecs[15];

    logic [31:0] addr_pool[14] = '{
        32'h0000_0000, 32'h0000_3FFF, 32'h0000_4000, 32'h0001_0000,
        32'h0001_FFFF, 32'h0002_0000, 32'h0002_FFFF, 32'h0003_0000,
        32'h1001_0000, 32'h1001_03FF, 32'h1001_0400, 32'h2000_0000,
        32'h201F_FFFF, 32'h2020_0000
    };

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] decode_ref(input logic [31:0] a);
        if (a < 32'h0000_4000) return 6'b000001;
        if (a >= 32'h0001_0000 && a < 32'h0002_0000) return 6'b000010;
        if (a >= 32'h0002_0000 && a < 32'h0003_0000) return 6'b000100;
        if ((a >= 32'h1001_0000 && a < 32'h1001_0400) ||
            (a >= 32'h2000_0000 && a < 32'h2020_0000)) return 6'b010000;
        return 6'b100000;
    endfunction

    // Beat k (1-based) sees count (k-1) mod 16; mismatch rules applied per beat.
    function automatic int err_ref(input int len, input int nbeats);
        int e = 0;
        for (int k = 1; k <= nbeats; k++) begin
            if (k == nbeats) begin
                if (((k - 1) % 16) != len) e++;
            end else begin
                if (((k - 1) % 16) == len) e++;
            end
        end
        return e;
    endfunction

    function automatic logic winner_ref(input int req);
        if (req == 3) return prio_m;
        return (req == 2);
    endfunction

    task automatic run_txn(input int req, input logic [31:0] a0, input logic [31:0] a1,
                           input logic [3:0] l0, input logic [3:0] l1, input int nbeats,
                           input int awd, input int bd, input bit stray_b, input bit gaps,
                           input bit hold, input logic [5:0] exp_sel, input int exp_errs,
                           output logic [1:0] grant_seen);
        logic       win;
        logic [1:0] eg;
        int         gcnt;
        int         errs;
        win = winner_ref(req);
        eg  = win ? 2'b10 : 2'b01;
        chk("idle_busy", {31'b0, busy_o}, 0);
        chk("idle_sel", {26'b0, slave_sel_o}, 0);
        chk("idle_grant", {30'b0, aw_grant_o}, 0);
        chk("idle_owner", {31'b0, w_owner_o}, {31'b0, last_owner});
        awvalid_m0_i = (req & 1) != 0;
        awvalid_m1_i = (req & 2) != 0;
        awaddr_m0_i  = a0;
        awaddr_m1_i  = a1;
        awlen_m0_i   = l0;
        awlen_m1_i   = l1;
        step();
        chk("addr_grant", {30'b0, aw_grant_o}, {30'b0, eg});
        chk("addr_sel", {26'b0, slave_sel_o}, {26'b0, exp_sel});
        chk("addr_owner", {31'b0, w_owner_o}, {31'b0, win});
        chk("addr_busy", {31'b0, busy_o}, 1);
        grant_seen = aw_grant_o;
        if (!hold) begin
            awvalid_m0_i = 1'b0;
            awvalid_m1_i = 1'b0;
        end
        gcnt = 1;
        for (int i = 0; i <= awd; i++) begin
            awready_i = (i == awd);
            step();
            if (aw_grant_o != 2'b00) gcnt++;
        end
        awready_i = 1'b0;
        chk("grant_cycles", gcnt, awd + 1);
        chk("data_grant", {30'b0, aw_grant_o}, 0);
        errs = 0;
        for (int k = 1; k <= nbeats; k++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                wvalid_i = 1'($urandom_range(0, 1));
                wready_i = ~wvalid_i;
                wlast_i  = 1'($urandom_range(0, 1));
                bvalid_i = stray_b;
                bready_i = stray_b;
                step();
                errs += int'(len_err_o);
            end
            wvalid_i = 1'b1;
            wready_i = 1'b1;
            wlast_i  = (k == nbeats);
            bvalid_i = stray_b;
            bready_i = stray_b;
            step();
            errs += int'(len_err_o);
            chk("data_busy", {31'b0, busy_o}, 1);
        end
        wvalid_i = 1'b0;
        wready_i = 1'b0;
        wlast_i  = 1'b0;
        chk("resp_sel", {26'b0, slave_sel_o}, {26'b0, exp_sel});
        chk("resp_owner", {31'b0, w_owner_o}, {31'b0, win});
        for (int i = 0; i <= bd; i++) begin
            bvalid_i = (i == bd) ? 1'b1 : 1'($urandom_range(0, 1));
            bready_i = (i == bd) ? 1'b1 : ~bvalid_i;
            step();
            errs += int'(len_err_o);
            if (i < bd) chk("resp_busy", {31'b0, busy_o}, 1);
        end
        bvalid_i = 1'b0;
        bready_i = 1'b0;
        chk("done_busy", {31'b0, busy_o}, 0);
        chk("done_sel", {26'b0, slave_sel_o}, 0);
        chk("len_err_count", errs, exp_errs);
        prio_m     = ~win;
        last_owner = win;
    endtask

    initial begin
        logic [1:0]  g;
        logic [1:0]  cont_exp[4];
        int          req, nb, lw;
        logic        w;
        logic [31:0] ra0, ra1;
        logic [3:0]  rl0, rl1;

        vecs[0]  = '{32'h0001_0004, 4'd3,  4,  6'b000010, 0};
        vecs[1]  = '{32'h0000_0000, 4'd0,  1,  6'b000001, 0};
        vecs[2]  = '{32'h0002_0000, 4'd1,  2,  6'b000100, 0};
        vecs[3]  = '{32'h1001_0000, 4'd2,  3,  6'b010000, 0};
        vecs[4]  = '{32'h2000_0010, 4'd0,  1,  6'b010000, 0};
        vecs[5]  = '{32'h3000_0000, 4'd0,  1,  6'b100000, 0};
        vecs[6]  = '{32'h0000_4000, 4'd0,  1,  6'b100000, 0};
        vecs[7]  = '{32'h1001_0400, 4'd0,  1,  6'b100000, 0};
        vecs[8]  = '{32'h201F_FFFF, 4'd0,  1,  6'b010000, 0};
        vecs[9]  = '{32'h0000_3FFF, 4'd0,  1,  6'b000001, 0};
        vecs[10] = '{32'h0001_0000, 4'd1,  1,  6'b000010, 1};
        vecs[11] = '{32'h0002_FFFF, 4'd0,  2,  6'b000100, 2};
        vecs[12] = '{32'h0000_0000, 4'd15, 16, 6'b000001, 0};
        vecs[13] = '{32'h0000_0000, 4'd3,  20, 6'b000001, 1};
        vecs[14] = '{32'h0000_0000, 4'd15, 17, 6'b000001, 2};
        cont_exp = '{2'b01, 2'b10, 2'b01, 2'b10};

        rst = 1'b1;
        awvalid_m0_i = 0; awvalid_m1_i = 0;
        awaddr_m0_i = 0;  awaddr_m1_i = 0;
        awlen_m0_i = 0;   awlen_m1_i = 0;
        awready_i = 0; wvalid_i = 0; wready_i = 0; wlast_i = 0;
        bvalid_i = 0; bready_i = 0;
        #3 rst = 1'b0;
        step();
        step();
        chk("rst_grant", {30'b0, aw_grant_o}, 0);
        chk("rst_owner", {31'b0, w_owner_o}, 0);
        chk("rst_sel", {26'b0, slave_sel_o}, 0);
        chk("rst_busy", {31'b0, busy_o}, 0);
        chk("rst_len_err", {31'b0, len_err_o}, 0);
        rst = 1'b1;
        step();

        // Contention: both masters hold awvalid across four transactions.
        for (int t = 0; t < 4; t++) begin
            run_txn(3, 32'h0000_0100, 32'h0001_0100, 4'd1, 4'd1, 2, t % 2, 1, 1'b0, 1'b0,
                    1'b1, decode_ref(winner_ref(3) ? 32'h0001_0100 : 32'h0000_0100), 0, g);
            chk("contend_grant", {30'b0, g}, {30'b0, cont_exp[t]});
        end
        awvalid_m0_i = 1'b0;
        awvalid_m1_i = 1'b0;

        for (int v = 0; v < 15; v++) begin
            run_txn(1, vecs[v].addr, 32'h0, vecs[v].len, 4'd0, vecs[v].nbeats, 1, 1,
                    1'b1, 1'b0, 1'b0, vecs[v].sel, vecs[v].errs, g);
        end

        // Stray W handshake while idle.
        wvalid_i = 1'b1; wready_i = 1'b1; wlast_i = 1'b1;
        step();
        chk("stray_w_busy", {31'b0, busy_o}, 0);
        step();
        chk("stray_w_busy2", {31'b0, busy_o}, 0);
        chk("stray_w_err", {31'b0, len_err_o}, 0);
        wvalid_i = 1'b0; wready_i = 1'b0; wlast_i = 1'b0;
        step();
        chk("stray_w_err2", {31'b0, len_err_o}, 0);

        for (int t = 0; t < 30; t++) begin
            req = int'($urandom_range(1, 3));
            ra0 = ($urandom_range(0, 3) == 0) ? $urandom : addr_pool[$urandom_range(0, 13)];
            ra1 = ($urandom_range(0, 3) == 0) ? $urandom : addr_pool[$urandom_range(0, 13)];
            rl0 = 4'($urandom_range(0, 15));
            rl1 = 4'($urandom_range(0, 15));
            nb  = int'($urandom_range(1, 18));
            w   = winner_ref(req);
            lw  = w ? int'(rl1) : int'(rl0);
            run_txn(req, ra0, ra1, rl0, rl1, nb, int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1, 1'b0,
                    decode_ref(w ? ra1 : ra0), err_ref(lw, nb), g);
        end

        // Mid-burst reset during M1's second beat.
        awvalid_m1_i = 1'b1; awaddr_m1_i = 32'h0002_0000; awlen_m1_i = 4'd0;
        step();
        awvalid_m1_i = 1'b0;
        awready_i = 1'b1;
        step();
        awready_i = 1'b0;
        wvalid_i = 1'b1; wready_i = 1'b1; wlast_i = 1'b0;
        step();
        chk("mb_err_before", {31'b0, len_err_o}, 1);
        chk("mb_owner_before", {31'b0, w_owner_o}, 1);
        chk("mb_busy_before", {31'b0, busy_o}, 1);
        #2 rst = 1'b0;
        #1;
        chk("mb_rst_grant", {30'b0, aw_grant_o}, 0);
        chk("mb_rst_owner", {31'b0, w_owner_o}, 0);
        chk("mb_rst_sel", {26'b0, slave_sel_o}, 0);
        chk("mb_rst_busy", {31'b0, busy_o}, 0);
        chk("mb_rst_err", {31'b0, len_err_o}, 0);
        wvalid_i = 1'b0; wready_i = 1'b0;
        step();
        step();
        rst = 1'b1;
        prio_m     = 1'b0;
        last_owner = 1'b0;
        step();
        run_txn(3, 32'h0000_0000, 32'h0001_0000, 4'd0, 4'd0, 1, 0, 0, 1'b0, 1'b0, 1'b0,
                6'b000001, 0, g);
        chk("post_rst_grant", {30'b0, g}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
